adder_8_bit_response_checker: RTL

ADDER_8_BIT_RESPONSE_CHECKER -- requirements
Module: adder_8_bit_response_checker

---
 rtl/adder_8_bit_response_checker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/adder_8_bit_response_checker.sv
// Response checker for an 8-bit adder: counts and flags mismatching vectors per run.
// Optional first-failure capture enabled by defining ADDER_CHECK_FAIL_CAPTURE_EN.
module adder_8_bit_response_checker #(
  parameter int NUM_VECTORS = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  sum,
  input  logic        c_out,
  input  logic        overflow,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [16:0] vec_count,
  output logic [15:0] err_count,
  output logic        fail_valid,
  output logic [7:0]  fail_a,
  output logic [7:0]  fail_b,
  output logic [9:0]  fail_resp
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  localparam logic [16:0] LAST_IDX = 17'(NUM_VECTORS - 1);

  state_t      state_q;
  logic [16:0] vec_q;
  logic [15:0] err_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;

  logic [8:0]  exp_sum_d;
  logic        exp_ov_d;
  logic        mismatch_d;
  logic        consume_d;
  logic        launch_d;
  logic [15:0] err_d;

  assign exp_sum_d  = {1'b0, a} + {1'b0, b};
  assign exp_ov_d   = (a[7] == b[7]) && (exp_sum_d[7] != a[7]);
  assign mismatch_d = (sum != exp_sum_d[7:0]) || (c_out != exp_sum_d[8]) ||
                      (overflow != exp_ov_d);
  assign consume_d  = (state_q == CHECK) && in_valid;
  assign launch_d   = (state_q != CHECK) && start;
  // Error counter sticks at all-ones rather than wrapping.
  assign err_d      = (mismatch_d && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= CHECK;
            vec_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        CHECK: begin
          if (in_valid) begin
            vec_q <= vec_q + 17'd1;
            err_q <= err_d;
            if (vec_q == LAST_IDX) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == 16'd0);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign vec_count = vec_q;
  assign err_count = err_q;

`ifdef ADDER_CHECK_FAIL_CAPTURE_EN
  logic       fail_valid_q;
  logic [7:0] fail_a_q;
  logic [7:0] fail_b_q;
  logic [9:0] fail_resp_q;

  // Only the first mismatch of a run is kept; a new start rearms the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_resp_q  <= '0;
    end else if (launch_d) begin
      fail_valid_q <= 1'b0;
    end else if (consume_d && mismatch_d && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_a_q     <= a;
      fail_b_q     <= b;
      fail_resp_q  <= {c_out, overflow, sum};
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_resp  = fail_resp_q;
`else
  logic unused_capture;
  assign unused_capture = launch_d ^ consume_d;
  assign fail_valid     = 1'b0;
  assign fail_a         = '0;
  assign fail_b         = '0;
  assign fail_resp      = '0;
`endif

endmodule
